fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the ARMv8 core. It owns the architectural fetch PC and issues one instruction-memory read request per accepted handshake. It advances the PC by 4 sequentially, or redirects it on branch, while holding address and request stable under memory back-pressure and pipeline stall. It is the requesting end of the instruction-memory address interface and replaces the free-running PC register with a handshaked source.

---
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch sequencer. Owns the architectural fetch PC and issues one
//   instruction-memory read request per accepted handshake. Advances the PC by
//   4 sequentially, or redirects it on branch. Address and request are held
//   stable under memory back-pressure and pipeline stall.
//
//   Optional feature macro: PC_ALIGN_CHECK_EN
//     defined   : misaligned branch targets become EXC_VECTOR, o_misalign pulses
//     undefined : target bits[1:0] forced to 0, o_misalign tied 0
//
// Ports
//   i_clk               clock, all state updates on posedge
//   i_reset             synchronous active-high reset
//   i_branch_valid      single-cycle redirect request
//   i_branch_target     redirect target (valid with i_branch_valid)
//   i_stall             pipeline stall, suppresses new requests
//   i_fetch_ready       instruction memory accepts the request
//   o_fetch_valid       request valid
//   o_adress            fetch address
//   o_redirect_pending  branch captured under back-pressure, not yet applied
//   o_fetch_count       accepted fetches, wraps at 2^32
//   o_misalign          one-cycle pulse after a misaligned branch target
module fetch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] EXC_VECTOR   = 64'h200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_branch_valid,
    input  logic [63:0] i_branch_target,
    input  logic        i_stall,
    input  logic        i_fetch_ready,
    output logic        o_fetch_valid,
    output logic [63:0] o_adress,
    output logic        o_redirect_pending,
    output logic [31:0] o_fetch_count,
    output logic        o_misalign
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic [63:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] count_q, count_d;
    logic [63:0] tgt_fixed;
    logic        handshake;

    // Sanitised branch target: every load or capture of a target goes through here.
`ifdef PC_ALIGN_CHECK_EN
    assign tgt_fixed = (i_branch_target[1:0] != 2'b00) ? EXC_VECTOR : i_branch_target;
`else
    assign tgt_fixed = {i_branch_target[63:2], 2'b00};
    // Low target bits and the exception vector have no function in this build.
    logic unused_align;
    assign unused_align = ^{i_branch_target[1:0], EXC_VECTOR};
`endif

    assign o_fetch_valid = (state_q == S_RUN);
    assign handshake     = o_fetch_valid && i_fetch_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        count_d    = count_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (i_branch_valid) addr_d = tgt_fixed;
            end
            S_RUN: begin
                if (handshake) begin
                    count_d = count_q + 32'd1;
                    // Live branch beats an older captured one.
                    if (i_branch_valid)  addr_d = tgt_fixed;
                    else if (pend_q)     addr_d = pend_tgt_q;
                    else                 addr_d = addr_q + 64'd4;
                    pend_d  = 1'b0;
                    state_d = i_stall ? S_STALL : S_RUN;
                end else if (i_branch_valid) begin
                    // Request must stay stable; park the youngest target.
                    pend_d     = 1'b1;
                    pend_tgt_d = tgt_fixed;
                end
            end
            S_STALL: begin
                // No request outstanding, so the address can change directly.
                if (i_branch_valid) addr_d = tgt_fixed;
                if (!i_stall)       state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_BOOT;
            addr_q     <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= 64'h0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            count_q    <= count_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) misalign_q <= 1'b0;
        else         misalign_q <= i_branch_valid && (i_branch_target[1:0] != 2'b00);
    end
    assign o_misalign = misalign_q;
`else
    assign o_misalign = 1'b0;
`endif

    assign o_adress           = addr_q;
    assign o_redirect_pending = pend_q;
    assign o_fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_branch_valid;
    logic [63:0] i_branch_target;
    logic        i_stall;
    logic        i_fetch_ready;
    logic        o_fetch_valid;
    logic [63:0] o_adress;
    logic        o_redirect_pending;
    logic [31:0] o_fetch_count;
    logic        o_misalign;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];

    fetch_sequencer #(.RESET_VECTOR(64'h0), .EXC_VECTOR(64'h200)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_branch_valid(i_branch_valid), .i_branch_target(i_branch_target),
        .i_stall(i_stall), .i_fetch_ready(i_fetch_ready),
        .o_fetch_valid(o_fetch_valid), .o_adress(o_adress),
        .o_redirect_pending(o_redirect_pending), .o_fetch_count(o_fetch_count),
        .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted request must match the next expected address.
    always @(negedge i_clk) begin
        if (!i_reset && o_fetch_valid && i_fetch_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected: got %h expected none", o_adress);
            end else begin
                chk("hs_addr", o_adress, sb_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [63:0] tgt, input logic st, input logic rdy);
        i_branch_valid  = br;
        i_branch_target = tgt;
        i_stall         = st;
        i_fetch_ready   = rdy;
    endtask

    typedef struct packed {
        logic        br;
        logic [63:0] tgt;
        logic        st;
        logic        rdy;
        logic        hs;
        logic [63:0] hs_addr;
        logic        e_valid;
        logic [63:0] e_addr;
        logic        e_pend;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[16];

    logic [63:0] exp_mis_addr;
    logic        exp_mis_pulse;

    initial begin
        //        br    tgt     st    rdy   hs    hs_addr  valid addr    pend  count
        vecs[0]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 64'h0,   1'b0, 32'd0};
        vecs[1]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h0,   1'b1, 64'h4,   1'b0, 32'd1};
        vecs[2]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h4,   1'b1, 64'h8,   1'b0, 32'd2};
        vecs[3]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h8,   1'b1, 64'hC,   1'b0, 32'd3};
        vecs[4]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'hC,   1'b1, 64'h10,  1'b0, 32'd4};
        vecs[5]  = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10,  1'b0, 32'd4};
        vecs[6]  = '{1'b1, 64'h100, 1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10,  1'b1, 32'd4};
        vecs[7]  = '{1'b1, 64'h200, 1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10,  1'b1, 32'd4};
        vecs[8]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h10,  1'b1, 64'h200, 1'b0, 32'd5};
        vecs[9]  = '{1'b1, 64'h1C,  1'b0, 1'b1, 1'b1, 64'h200, 1'b1, 64'h1C,  1'b0, 32'd6};
        vecs[10] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h1C,  1'b1, 64'h20,  1'b0, 32'd7};
        vecs[11] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 64'h20,  1'b0, 64'h24,  1'b0, 32'd8};
        vecs[12] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h24,  1'b0, 32'd8};
        vecs[13] = '{1'b1, 64'h80,  1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h80,  1'b0, 32'd8};
        vecs[14] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 64'h80,  1'b0, 32'd8};
        vecs[15] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h80,  1'b1, 64'h84,  1'b0, 32'd9};

`ifdef PC_ALIGN_CHECK_EN
        exp_mis_addr  = 64'h200;
        exp_mis_pulse = 1'b1;
`else
        exp_mis_addr  = 64'h100;
        exp_mis_pulse = 1'b0;
`endif

        // Reset state
        i_reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_valid", {63'h0, o_fetch_valid}, 64'h0);
        chk("rst_addr", o_adress, 64'h0);
        chk("rst_pend", {63'h0, o_redirect_pending}, 64'h0);
        chk("rst_count", {32'h0, o_fetch_count}, 64'h0);
        chk("rst_mis", {63'h0, o_misalign}, 64'h0);

        // Sequential, back-pressure with youngest-wins, stall with branch
        i_reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].br, vecs[i].tgt, vecs[i].st, vecs[i].rdy);
            if (vecs[i].hs) sb_q.push_back(vecs[i].hs_addr);
            cyc();
            chk($sformatf("v%0d_valid", i), {63'h0, o_fetch_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_addr", i), o_adress, vecs[i].e_addr);
            chk($sformatf("v%0d_pend", i), {63'h0, o_redirect_pending}, {63'h0, vecs[i].e_pend});
            chk($sformatf("v%0d_count", i), {32'h0, o_fetch_count}, {32'h0, vecs[i].e_count});
        end

        // Wrap at top of address space
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
        sb_q.push_back(64'h84);
        cyc();
        chk("wrap_tgt", o_adress, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        chk("wrap_zero", o_adress, 64'h0);

        // Misaligned branch target
        drive(1'b1, 64'h103, 1'b0, 1'b1);
        sb_q.push_back(64'h0);
        cyc();
        chk("mis_addr", o_adress, exp_mis_addr);
        chk("mis_pulse", {63'h0, o_misalign}, {63'h0, exp_mis_pulse});
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        cyc();
        chk("mis_pulse_end", {63'h0, o_misalign}, 64'h0);
        chk("mis_count", {32'h0, o_fetch_count}, 64'd12);

        // Reset while blocked with a pending branch
        drive(1'b1, 64'h300, 1'b0, 1'b0);
        cyc();
        chk("pre_rst_pend", {63'h0, o_redirect_pending}, 64'h1);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        i_reset = 1'b1;
        cyc();
        chk("mrst_pend", {63'h0, o_redirect_pending}, 64'h0);
        chk("mrst_addr", o_adress, 64'h0);
        chk("mrst_valid", {63'h0, o_fetch_valid}, 64'h0);
        chk("mrst_count", {32'h0, o_fetch_count}, 64'h0);

        // One BOOT cycle before the first request
        i_reset = 1'b0;
        cyc();
        chk("boot_valid", {63'h0, o_fetch_valid}, 64'h1);
        chk("boot_addr", o_adress, 64'h0);
        chk("boot_pend", {63'h0, o_redirect_pending}, 64'h0);

        chk("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
